// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decoder with output handshake and multi-cycle mult/div sequencing
module alu_ctrl_seq #(
    parameter int CTRL_W = 4,
    parameter int MD_LAT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluOp,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] aluControl,
    output logic              err,
    output logic              md_busy,
    output logic              md_start
);
    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    typedef enum logic {IDLE, MD_BUSY} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] ctrl_q, ctrl_d, dec_ctrl;
    logic out_valid_q, out_valid_d, err_q, err_d, md_start_q, md_start_d;
    logic dec_err, dec_md, accept;
    assign in_ready   = !flush && state_q == IDLE && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign err        = err_q;
    assign md_busy    = state_q == MD_BUSY;
    assign md_start   = md_start_q;
    assign aluControl = CTRL_W'(ctrl_q);
    // decode aluOp/funct into a 4-bit control code; anything unlisted is illegal
    always_comb begin
        dec_ctrl = 4'b1111;
        dec_err  = 1'b1;
        dec_md   = 1'b0;
        case (aluOp)
            2'b00: {dec_ctrl, dec_err} = {4'b0010, 1'b0};
            2'b01: {dec_ctrl, dec_err} = {4'b0110, 1'b0};
            2'b10:
                case (funct)
                    6'b100000: {dec_ctrl, dec_err} = {4'b0010, 1'b0};
                    6'b100010: {dec_ctrl, dec_err} = {4'b0110, 1'b0};
                    6'b100100: {dec_ctrl, dec_err} = {4'b0000, 1'b0};
                    6'b100101: {dec_ctrl, dec_err} = {4'b0001, 1'b0};
                    6'b101010: {dec_ctrl, dec_err} = {4'b0111, 1'b0};
                    6'b100111: {dec_ctrl, dec_err} = {4'b1100, 1'b0};
                    6'b011000: {dec_ctrl, dec_err, dec_md} = {4'b1000, 1'b0, 1'b1};
                    6'b011010: {dec_ctrl, dec_err, dec_md} = {4'b1001, 1'b0, 1'b1};
                    default: ;
                endcase
            default: ;
        endcase
    end
    // next state: flush beats everything, then mult/div countdown, then acceptance, then drain
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        md_start_d  = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            err_d       = 1'b0;
        end else if (state_q == MD_BUSY) begin
            if (cnt_q == '0) begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (accept) begin
            ctrl_d      = dec_ctrl;
            err_d       = dec_err;
            out_valid_d = !dec_md;
            md_start_d  = dec_md;
            state_d     = dec_md ? MD_BUSY : IDLE;
            cnt_d       = dec_md ? CW'(MD_LAT - 1) : cnt_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            err_d       = 1'b0;
        end
    end
    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            md_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            md_start_q  <= md_start_d;
        end
    end
endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter CTRL_W, default 4, ALU control output width; SHALL be >= 4.
REQ-002 Parameter MD_LAT, default 32, multiply/divide occupancy in cycles; SHALL be >= 2.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous abort of held output and any multi-cycle op.
REQ-006 in_valid  input  1  decode request present.
REQ-007 in_ready  output  1  request accepted this cycle when in_valid & in_ready.
REQ-008 aluOp  input  2  main-control ALU operation class.
REQ-009 funct  input  6  R-type function field.
REQ-010 out_valid  output  1  aluControl/err hold a result.
REQ-011 out_ready  input  1  consumer takes result when out_valid & out_ready.
REQ-012 aluControl  output  CTRL_W  decoded ALU control, zero-extended from 4 bits.
REQ-013 err  output  1  result came from an illegal aluOp/funct.
REQ-014 md_busy  output  1  multiply/divide sequence in progress.
REQ-015 md_start  output  1  one-cycle pulse on acceptance of mult/div.

Function
REQ-016 Decode SHALL be: aluOp 00 -> 0010; aluOp 01 -> 0110; aluOp 11 -> 1111 with err=1.
REQ-017 aluOp 10 SHALL decode funct: 100000 -> 0010 (add), 100010 -> 0110 (sub), 100100 -> 0000 (and), 100101 -> 0001 (or), 101010 -> 0111 (slt), 100111 -> 1100 (nor), 011000 -> 1000 (mult), 011010 -> 1001 (div); any other funct -> 1111 with err=1.
REQ-018 err SHALL be 0 for every legal code.
REQ-019 in_ready SHALL equal !flush & !md_busy & (!out_valid | out_ready).
REQ-020 Single-cycle op accepted at edge N: out_valid=1 with aluControl/err from edge N (latency 1).
REQ-021 Output register SHALL hold aluControl/err stable while out_valid & !out_ready.
REQ-022 out_valid SHALL clear on out_ready unless a new request is accepted in the same cycle, in which case it stays 1 with the new result (back-to-back, 1 result per cycle).
REQ-023 States: IDLE, MD_BUSY. IDLE -> MD_BUSY on acceptance of mult/div; md_start pulses in the cycle after acceptance; internal counter loads MD_LAT-1.
REQ-024 In MD_BUSY: md_busy=1, out_valid=0, counter decrements by 1 per cycle; at counter 0 the FSM SHALL return to IDLE, set out_valid=1 with 1000/1001, total accept-to-out_valid latency MD_LAT cycles.
REQ-025 Counter width SHALL be clog2(MD_LAT); no wrap: counter never decrements below 0.
REQ-026 flush SHALL, at the next edge, clear out_valid and md_busy, force IDLE, clear counter; no request is accepted in a flush cycle (flush wins over in_valid and over MD completion in the same cycle).
REQ-027 err SHALL be cleared whenever out_valid is cleared.
REQ-028 Inputs with in_valid=0 SHALL have no effect on any state.

Reset
REQ-029 On rst_n=0 (asynchronous): state IDLE, counter 0, out_valid 0, aluControl all zeros, err 0, md_busy 0, md_start 0; in_ready follows REQ-019 (=1 unless flush).
REQ-030 Reset asserted mid MD_BUSY SHALL abort the sequence with no result emitted after release.
REQ-031 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 aluOp=01, funct=000000, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, aluControl=0110, err=0.
REQ-033 R-type stream add, sub, and, or, slt, nor on consecutive cycles with out_ready=1 -> results 0010, 0110, 0000, 0001, 0111, 1100 on consecutive cycles, in_ready held 1.
REQ-034 aluOp=10, funct=011000, MD_LAT=32 -> md_start one cycle, md_busy for 32 cycles, in_ready=0 throughout, out_valid=1 with 1000 exactly 32 cycles after acceptance.
REQ-035 out_ready=0 for 5 cycles after an add result -> aluControl stays 0010, in_ready=0; out_ready=1 -> accepted, out_valid drops next cycle.
REQ-036 aluOp=10, funct=111111 -> aluControl=1111, err=1; then flush during a div at cycle 10 -> md_busy=0 next cycle, no result emitted.
REQ-037 rst_n low mid-div for 1 cycle -> all outputs at reset values immediately, no output after release; CTRL_W=8 build -> aluControl=00000010 for add.
